// File: rtl/snp_capture_if.sv
// snp_capture_if
//   Bundles the snapshot capture controller's software, sample-stream and
//   BRAM-write signals.
//
//   Signals:
//     ctrl       software control word (bit0 arm, bit1 trig_sel)
//     din        sample data
//     din_valid  sample qualifier
//     ext_trig   external trigger level
//     stop       ends a circular capture
//     bram_we    BRAM write enable (one-cycle pulse per sample)
//     bram_addr  BRAM write address
//     bram_din   BRAM write data
//     last_addr  address of the most recent write
//     status     status word for the snapshot status register
//     fsm_state  controller state, for observation only
//
//   Handshake: din_valid is a pure qualifier with no back-pressure. A sample
//   is taken on every rising edge where din_valid is high and the controller
//   can write it; the controller never stalls the stream, so there is no
//   ready signal and unaccepted samples are simply dropped.
//
//   Modports: master drives the controller inputs (software/sample side);
//   slave is the controller itself.
interface snp_capture_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic [31:0]       ctrl;
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              ext_trig;
  logic              stop;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_din;
  logic [ADDR_W-1:0] last_addr;
  logic [31:0]       status;
  logic [1:0]        fsm_state;

  modport master (
    output ctrl, din, din_valid, ext_trig, stop,
    input  bram_we, bram_addr, bram_din, last_addr, status, fsm_state
  );

  modport slave (
    input  ctrl, din, din_valid, ext_trig, stop,
    output bram_we, bram_addr, bram_din, last_addr, status, fsm_state
  );
endinterface

// File: rtl/snp_capture_ctrl.sv
// snp_capture_ctrl
//   Capture sequencer for one snapshot buffer. A rising edge on ctrl[0] arms
//   the buffer; after the trigger the qualified sample stream is written into
//   BRAM through one registered write stage, and a 32-bit status word reports
//   done / busy / wrapped / sample count.
//
//   Ports:
//     user_clk   DSP clock, rising edge
//     user_rst   synchronous active-high reset
//     bus        snp_capture_if.slave (ctrl, din, din_valid, ext_trig, stop,
//                bram_we, bram_addr, bram_din, last_addr, status, fsm_state)
//
//   Configuration:
//     SNP_CIRC_CAPTURE_EN  when defined, capture is circular: the pointer
//                          wraps, wrapped is reported, and stop ends the
//                          capture. When undefined, capture is one-shot to
//                          full, stop is ignored and wrapped stays 0.
//
//   Status word: [31] done, [30] busy, [29] wrapped, [ADDR_W:0] count.
module snp_capture_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic          user_clk,
  input  logic          user_rst,
  snp_capture_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TRIG = 2'd1,
    CAPTURE   = 2'd2,
    DONE      = 2'd3
  } state_t;

  localparam logic [ADDR_W:0]   FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] LAST_PTR = '1;

  state_t            state;
  logic              arm_q;
  logic              arm_re;
  logic              trig;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   count;
  logic              wrapped;
  logic              done_q;
  logic              busy_q;

  // arm_q resets to 0, so ctrl[0] already high at reset release is an edge.
  assign arm_re = bus.ctrl[0] & ~arm_q;
  assign trig   = bus.ctrl[1] ? bus.ext_trig : 1'b1;

  // Only bit0/bit1 of ctrl matter; stop matters only for circular capture.
  logic unused_inputs;
  assign unused_inputs = ^{bus.ctrl[31:2], bus.stop};

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state         <= IDLE;
      arm_q         <= 1'b0;
      ptr           <= '0;
      count         <= '0;
      wrapped       <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
      bus.bram_we   <= 1'b0;
      bus.bram_addr <= '0;
      bus.bram_din  <= '0;
      bus.last_addr <= '0;
    end else begin
      arm_q       <= bus.ctrl[0];
      bus.bram_we <= 1'b0;

      if (arm_re) begin
        // Re-arm wins in every state, including mid-capture; the sample
        // presented in this cycle is not written.
        state   <= WAIT_TRIG;
        ptr     <= '0;
        count   <= '0;
        wrapped <= 1'b0;
        done_q  <= 1'b0;
        busy_q  <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
          end

          WAIT_TRIG: begin
            // The trigger only latches together with a valid sample, which
            // becomes the first word at address 0.
            if (trig && bus.din_valid) begin
              bus.bram_we   <= 1'b1;
              bus.bram_addr <= '0;
              bus.bram_din  <= bus.din;
              bus.last_addr <= '0;
              ptr           <= {{(ADDR_W-1){1'b0}}, 1'b1};
              count         <= {{ADDR_W{1'b0}}, 1'b1};
              state         <= CAPTURE;
            end
          end

          CAPTURE: begin
`ifdef SNP_CIRC_CAPTURE_EN
            if (bus.stop) begin
              state  <= DONE;
              done_q <= 1'b1;
              busy_q <= 1'b0;
            end else if (bus.din_valid) begin
              bus.bram_we   <= 1'b1;
              bus.bram_addr <= ptr;
              bus.bram_din  <= bus.din;
              bus.last_addr <= ptr;
              ptr           <= ptr + 1'b1;
              if (count != FULL_CNT) count <= count + 1'b1;
              // Address 0 in CAPTURE is always a revisit: the first word
              // at address 0 was written from WAIT_TRIG.
              if (ptr == '0) wrapped <= 1'b1;
            end
`else
            if (bus.din_valid) begin
              bus.bram_we   <= 1'b1;
              bus.bram_addr <= ptr;
              bus.bram_din  <= bus.din;
              bus.last_addr <= ptr;
              ptr           <= ptr + 1'b1;
              if (count != FULL_CNT) count <= count + 1'b1;
              if (ptr == LAST_PTR) begin
                state  <= DONE;
                done_q <= 1'b1;
                busy_q <= 1'b0;
              end
            end
`endif
          end

          DONE: begin
          end

          default: begin
            state  <= IDLE;
            done_q <= 1'b0;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  // Status is a plain concatenation of flops: no path from any input.
  assign bus.status    = {done_q, busy_q, wrapped, {(28-ADDR_W){1'b0}}, count};
  assign bus.fsm_state = state;

endmodule
